// File: rtl/conv_mem_pkg.sv
// Shared constants and types for the conv-result memory arbiter slice.
package conv_mem_pkg;
  localparam int CM_AW     = 12;  // 64x64 map
  localparam int CM_DW     = 13;  // signed 9.4 fixed point
  localparam int CM_RD_LAT = 1;

  localparam logic LAYER0   = 1'b0;
  localparam logic LAYER1   = 1'b1;
  localparam logic REQ_CONV = 1'b0;
  localparam logic REQ_RDBK = 1'b1;

  typedef struct packed {
    logic vld;
    logic id;
  } rd_tag_t;
endpackage

// File: rtl/conv_mem_arbiter_if.sv
// Requester handshake and conv-memory port bundles. ARB_LOCK_EN adds a lock
// line to the requester bundle.
interface conv_req_if #(
  parameter int AW = conv_mem_pkg::CM_AW,
  parameter int DW = conv_mem_pkg::CM_DW
);
  logic          req;
  logic          we;
  logic          sel;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
`ifdef ARB_LOCK_EN
  logic          lock;
  modport master (output req, we, sel, addr, wdata, lock, input gnt, rvalid);
  modport slave  (input req, we, sel, addr, wdata, lock, output gnt, rvalid);
`else
  modport master (output req, we, sel, addr, wdata, input gnt, rvalid);
  modport slave  (input req, we, sel, addr, wdata, output gnt, rvalid);
`endif
endinterface

interface conv_cmem_if #(
  parameter int AW = conv_mem_pkg::CM_AW,
  parameter int DW = conv_mem_pkg::CM_DW
);
  logic          cwr;
  logic          crd;
  logic [AW-1:0] caddr_wr;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_wr;
  logic [DW-1:0] cdata_rd;
  logic          csel;
  modport master (output cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel, input cdata_rd);
  modport slave  (input cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel, output cdata_rd);
endinterface

// File: rtl/conv_mem_arbiter_tag_pipe.sv
// RD_LAT-deep shift register of {valid, id} tags tracking reads in the memory.
module conv_rd_tag_pipe import conv_mem_pkg::*; #(
  parameter int RD_LAT = CM_RD_LAT
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out,
  output logic    any_vld
);
  rd_tag_t tag_pipe [RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_out = tag_pipe[RD_LAT-1];

  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < RD_LAT; i++) any_vld = any_vld | tag_pipe[i].vld;
  end
endmodule

// File: rtl/conv_mem_arbiter.sv
// Round-robin arbiter sharing the conv-result memory port between the conv
// writer (0) and readback reader (1). ARB_LOCK_EN enables owner lock bursts.
module conv_mem_arbiter import conv_mem_pkg::*; #(
  parameter int AW     = CM_AW,
  parameter int DW     = CM_DW,
  parameter int RD_LAT = CM_RD_LAT
) (
  input  logic          clk,
  input  logic          reset,
  conv_req_if.slave     rq0,
  conv_req_if.slave     rq1,
  conv_cmem_if.master   mem,
  output logic [DW-1:0] rdata,
  output logic          busy
);
  logic [1:0]    req;
  logic          prio, gid, gnt_any, cmd_id;
  logic          we_g, sel_g;
  logic [AW-1:0] addr_g;
  logic [DW-1:0] wdata_g;
  rd_tag_t       tag_in, tag_out;
  logic          tag_busy;

  assign req     = {rq1.req, rq0.req};
  assign gnt_any = |req;

`ifdef ARB_LOCK_EN
  logic [1:0] lock;
  logic       lock_act, lock_id, hold;
  assign lock = {rq1.lock, rq0.lock};
  // owner keeps the port while it still requests with lock asserted
  assign hold = lock_act && req[lock_id] && lock[lock_id];
`endif

  always_comb begin
    gid = prio;
    if (req == 2'b01)      gid = REQ_CONV;
    else if (req == 2'b10) gid = REQ_RDBK;
`ifdef ARB_LOCK_EN
    if (hold) gid = lock_id;
`endif
  end

  assign rq0.gnt = gnt_any & ~gid;
  assign rq1.gnt = gnt_any & gid;
  assign we_g    = gid ? rq1.we    : rq0.we;
  assign sel_g   = gid ? rq1.sel   : rq0.sel;
  assign addr_g  = gid ? rq1.addr  : rq0.addr;
  assign wdata_g = gid ? rq1.wdata : rq0.wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio         <= REQ_CONV;
      cmd_id       <= REQ_CONV;
      mem.cwr      <= 1'b0;
      mem.crd      <= 1'b0;
      mem.csel     <= LAYER0;
      mem.caddr_wr <= '0;
      mem.caddr_rd <= '0;
      mem.cdata_wr <= '0;
      rdata        <= '0;
      rq0.rvalid   <= 1'b0;
      rq1.rvalid   <= 1'b0;
    end else begin
      mem.cwr    <= gnt_any & we_g;
      mem.crd    <= gnt_any & ~we_g;
      rq0.rvalid <= tag_out.vld & ~tag_out.id;
      rq1.rvalid <= tag_out.vld & tag_out.id;
      if (tag_out.vld) rdata <= mem.cdata_rd;
      if (gnt_any) begin
        prio     <= ~gid;
        cmd_id   <= gid;
        mem.csel <= sel_g;
        if (we_g) begin
          mem.caddr_wr <= addr_g;
          mem.cdata_wr <= wdata_g;
        end else begin
          mem.caddr_rd <= addr_g;
        end
      end
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_act <= 1'b0;
      lock_id  <= REQ_CONV;
    end else if (gnt_any) begin
      lock_act <= lock[gid];
      lock_id  <= gid;
    end
  end
`endif

  // tag enters alongside the registered crd, i.e. when the memory samples it
  assign tag_in = '{vld: mem.crd, id: cmd_id};

  conv_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out),
    .any_vld (tag_busy)
  );

  assign busy = tag_busy | mem.cwr | mem.crd;
endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Randomized bench for conv_mem_arbiter against a transaction-level model:
// grant order, memory command, read return schedule and busy.
module tb_conv_mem_arbiter;
  import conv_mem_pkg::*;
  localparam int AW = CM_AW, DW = CM_DW, LAT = CM_RD_LAT, NCYC = 1024;

  logic clk = 1'b0, reset;
  logic [DW-1:0] rdata;
  logic busy;

  conv_req_if  #(.AW(AW), .DW(DW)) rq0 ();
  conv_req_if  #(.AW(AW), .DW(DW)) rq1 ();
  conv_cmem_if #(.AW(AW), .DW(DW)) mem ();

  conv_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .rq0(rq0), .rq1(rq1), .mem(mem),
    .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // memory behind the port: synchronous write, LAT-cycle read
  logic [DW-1:0] marr [2][1<<AW];
  logic [DW-1:0] rpipe [LAT];
  always @(posedge clk) begin
    if (mem.cwr) marr[mem.csel][mem.caddr_wr] <= mem.cdata_wr;
    rpipe[0] <= mem.crd ? marr[mem.csel][mem.caddr_rd] : '0;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem.cdata_rd = rpipe[LAT-1];

  // reference state
  logic [DW-1:0] gold [2][1<<AW];
  bit            prio_m, own_vld, own_id;
  bit            e_cwr, e_crd, e_csel;
  logic [AW-1:0] e_wa, e_ra;
  logic [DW-1:0] e_wd, e_rdata;
  bit            sv [NCYC];
  bit            sid [NCYC];
  logic [DW-1:0] sdat [NCYC];
  int            cyc, total, bad;
  bit            mg0, mg1, og0, og1, orv0, orv1;
  logic [DW-1:0] ordata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    prio_m = 0; own_vld = 0; own_id = 0;
    e_cwr = 0; e_crd = 0; e_csel = 0; e_wa = '0; e_ra = '0; e_wd = '0; e_rdata = '0;
    for (int i = 0; i < NCYC; i++) sv[i] = 0;
  endtask

  task automatic set_req(input int r, input bit q, input bit we, input bit sel,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input bit lk);
    if (r == 0) begin
      rq0.req = q; rq0.we = we; rq0.sel = sel; rq0.addr = a; rq0.wdata = d;
`ifdef ARB_LOCK_EN
      rq0.lock = lk;
`endif
    end else begin
      rq1.req = q; rq1.we = we; rq1.sel = sel; rq1.addr = a; rq1.wdata = d;
`ifdef ARB_LOCK_EN
      rq1.lock = lk;
`endif
    end
  endtask

  task automatic rand_req(input int r);
    set_req(r, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 15)), DW'($urandom), $urandom_range(0, 3) == 0);
  endtask

  // one clock: check every output mid-cycle, then advance the model over the edge
  task automatic tick();
    bit ga, gi, pend, we, sel, lk;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int k;
    @(negedge clk);
    ga = rq0.req | rq1.req;
    gi = (rq0.req && rq1.req) ? prio_m : rq1.req;
`ifdef ARB_LOCK_EN
    if (own_vld && (own_id ? (rq1.req && rq1.lock) : (rq0.req && rq0.lock))) gi = own_id;
`endif
    chk("gnt0", rq0.gnt, ga && !gi);
    chk("gnt1", rq1.gnt, ga && gi);
    chk("cwr", mem.cwr, e_cwr);
    chk("crd", mem.crd, e_crd);
    chk("csel", mem.csel, e_csel);
    chk("caddr_wr", mem.caddr_wr, e_wa);
    chk("caddr_rd", mem.caddr_rd, e_ra);
    chk("cdata_wr", mem.cdata_wr, e_wd);
    chk("rvalid0", rq0.rvalid, sv[cyc%NCYC] && !sid[cyc%NCYC]);
    chk("rvalid1", rq1.rvalid, sv[cyc%NCYC] && sid[cyc%NCYC]);
    chk("rdata", rdata, e_rdata);
    pend = e_cwr | e_crd;
    for (int j = 1; j <= LAT + 1; j++) if (sv[(cyc+j)%NCYC]) pend = 1;
    chk("busy", busy, pend);
    og0 = rq0.gnt; og1 = rq1.gnt; orv0 = rq0.rvalid; orv1 = rq1.rvalid; ordata = rdata;
    mg0 = ga && !gi && !reset; mg1 = ga && gi && !reset;
    @(posedge clk);
    #1;
    sv[cyc%NCYC] = 0;
    cyc++;
    if (reset) begin
      model_reset();
    end else begin
      if (sv[cyc%NCYC]) e_rdata = sdat[cyc%NCYC];
      e_cwr = 0; e_crd = 0;
      if (ga) begin
        we = gi ? rq1.we : rq0.we;
        sel = gi ? rq1.sel : rq0.sel;
        a = gi ? rq1.addr : rq0.addr;
        d = gi ? rq1.wdata : rq0.wdata;
`ifdef ARB_LOCK_EN
        lk = gi ? rq1.lock : rq0.lock;
`else
        lk = 0;
`endif
        prio_m = !gi; own_vld = lk; own_id = gi; e_csel = sel;
        if (we) begin
          e_cwr = 1; e_wa = a; e_wd = d; gold[sel][a] = d;
        end else begin
          e_crd = 1; e_ra = a;
          k = (cyc + LAT + 1) % NCYC;
          sv[k] = 1; sid[k] = gi; sdat[k] = gold[sel][a];
        end
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seq [4];
    bit seen;
    logic [DW-1:0] got;
    int n0;
    reset = 1;
    set_req(0, 0, 0, 0, '0, '0, 0);
    set_req(1, 0, 0, 0, '0, '0, 0);
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < (1 << AW); a++) begin
        got = DW'($urandom);
        marr[b][a] = got;
        gold[b][a] = got;
      end
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    cyc = 0;
    reset = 0;
    tick(); tick();
    chk("idle_gnt", {og1, og0}, 2'b00);

    // single write from requester 0
    set_req(0, 1, 1, LAYER1, 12'h005, 13'h0030, 0);
    tick();
    chk("wr_gnt0", og0, 1);
    set_req(0, 0, 0, 0, '0, '0, 0);
    chk("wr_cwr", mem.cwr, 1);
    chk("wr_addr", mem.caddr_wr, 12'h005);
    chk("wr_data", mem.cdata_wr, 13'h0030);
    chk("wr_csel", mem.csel, 1);
    tick();

    // contention: both read, grants must alternate from requester 0
    reset = 1; tick(); reset = 0;
    set_req(0, 1, 0, LAYER0, 12'h020, '0, 0);
    set_req(1, 1, 0, LAYER1, 12'h021, '0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      seq[i] = og1;
      if (mg0) set_req(0, 1, 0, LAYER0, AW'(12'h030 + i), '0, 0);
      if (mg1) set_req(1, 1, 0, LAYER1, AW'(12'h040 + i), '0, 0);
    end
    chk("alt0", seq[0], 0); chk("alt1", seq[1], 1);
    chk("alt2", seq[2], 0); chk("alt3", seq[3], 1);
    set_req(0, 0, 0, 0, '0, '0, 0);
    set_req(1, 0, 0, 0, '0, '0, 0);
    repeat (LAT + 3) tick();

    // write then immediate read of the same location
    set_req(0, 1, 1, LAYER0, 12'hFFF, 13'h0111, 0);
    tick();
    set_req(0, 1, 0, LAYER0, 12'hFFF, '0, 0);
    tick();
    set_req(0, 0, 0, 0, '0, '0, 0);
    seen = 0; got = '0;
    for (int i = 0; i < LAT + 4 && !seen; i++) begin
      tick();
      if (orv0) begin seen = 1; got = ordata; end
    end
    chk("raw_seen", seen, 1);
    chk("raw_rdata", got, 13'h0111);

    // reset with two reads in flight
    set_req(0, 1, 0, LAYER0, 12'h003, '0, 0);
    set_req(1, 1, 0, LAYER1, 12'h004, '0, 0);
    tick();
    if (mg0) set_req(0, 0, 0, 0, '0, '0, 0);
    if (mg1) set_req(1, 0, 0, 0, '0, '0, 0);
    tick();
    set_req(0, 0, 0, 0, '0, '0, 0);
    set_req(1, 0, 0, 0, '0, '0, 0);
    reset = 1;
    tick();
    chk("rst_busy", busy, 0);
    reset = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      chk("rst_rvalid", {orv1, orv0}, 2'b00);
    end

`ifdef ARB_LOCK_EN
    // locked burst of 4 writes against a continuous requester 1
    reset = 1; tick(); reset = 0;
    set_req(1, 1, 1, LAYER1, 12'h100, 13'h0005, 0);
    n0 = 0;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, 1, LAYER0, AW'(12'h200 + i), DW'(i + 1), 1);
      tick();
      if (og0) n0++;
    end
    chk("lock_burst", n0, 4);
    set_req(0, 1, 1, LAYER0, 12'h210, 13'h0009, 0);
    tick();
    chk("lock_release", og1, 1);
    set_req(0, 0, 0, 0, '0, '0, 0);
    set_req(1, 0, 0, 0, '0, '0, 0);
    tick();
`endif

    // randomized traffic, each requester holding until granted
    mg0 = 0; mg1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (mg0 || !rq0.req) rand_req(0);
      if (mg1 || !rq1.req) rand_req(1);
      tick();
    end
    set_req(0, 0, 0, 0, '0, '0, 0);
    set_req(1, 0, 0, 0, '0, '0, 0);
    repeat (LAT + 3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
